izh_neuron_scheduler: RTL and testbench

- Time-multiplexes one 8-bit Izhikevich update datapath across NUM_NEURONS virtual neurons.
- Holds per-neuron v, u and input current in a register file.
- On each tick pulse, steps every neuron once in index order and writes the results back.
- Spike events go out as neuron indices through a small FIFO with a valid/ready handshake.
- Sits between the stimulus/config host and the spike-routing logic.

---
 rtl/izh_pkg.sv | 25 ++
 rtl/izh_step_core.sv | 28 ++
 rtl/izh_neuron_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_izh_neuron_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared constants and types for the time-multiplexed Izhikevich neuron scheduler.
package izh_pkg;

  localparam logic [7:0] IZH_A      = 8'd24;
  localparam logic [7:0] IZH_B      = 8'd8;
  localparam logic [7:0] IZH_C      = 8'd60;
  localparam logic [7:0] IZH_D      = 8'd4;
  localparam logic [7:0] IZH_THRESH = 8'd232;

  localparam logic [1:0] CFG_SEL_CUR = 2'd0;
  localparam logic [1:0] CFG_SEL_V   = 2'd1;
  localparam logic [1:0] CFG_SEL_U   = 2'd2;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] u;
  } izh_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL
  } sched_state_t;

endpackage

// File: rtl/izh_step_core.sv
// One combinational Izhikevich step on 8-bit modulo-256 state.
// Products are formed at 16 bits and truncated after the shift.
module izh_step_core
  import izh_pkg::*;
(
  input  logic [7:0] v,
  input  logic [7:0] u,
  input  logic [7:0] cur,
  output logic [7:0] v_next,
  output logic [7:0] u_next,
  output logic       spike
);

  logic [7:0] sq_term;
  logic [7:0] lin_term;
  logic [7:0] t;
  logic [7:0] u_step;

  assign sq_term  = 8'((16'd2 * {8'd0, v} * {8'd0, v}) >> 7);
  assign lin_term = 8'(16'd5 * {8'd0, v});
  assign t        = 8'({8'd0, IZH_B} * {8'd0, v}) - u;
  assign u_step   = 8'(({8'd0, IZH_A} * {8'd0, t}) >> 7);

  assign spike  = (v >= IZH_THRESH);
  assign v_next = spike ? IZH_C : (v + sq_term + lin_term - u + cur);
  assign u_next = spike ? (u + IZH_D) : (u + u_step);

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Steps NUM_NEURONS virtual neurons once per tick through a shared datapath; spikes leave via a FIFO.
// Define IZH_SCHED_REFRACTORY_EN to add a per-neuron refractory counter.
module izh_neuron_scheduler
  import izh_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS),
  parameter int FIFO_DEPTH  = 4
`ifdef IZH_SCHED_REFRACTORY_EN
  ,
  parameter int REFRAC_TICKS = 2
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  output logic             busy,
  output logic             tick_done,
  output logic             tick_overrun,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_v,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_idx
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] idx;

  izh_state_t       st_mem  [NUM_NEURONS];
  logic [7:0]       cur_mem [NUM_NEURONS];

  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]    wr_ptr;
  logic [FW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_cnt;

  izh_state_t cur_st;
  izh_state_t core_nxt;
  izh_state_t nxt;
  logic       core_spike;
  logic       spike;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       stall;
  logic       commit;

  assign cur_st = st_mem[idx];

  izh_step_core u_core (
    .v      (cur_st.v),
    .u      (cur_st.u),
    .cur    (cur_mem[idx]),
    .v_next (core_nxt.v),
    .u_next (core_nxt.u),
    .spike  (core_spike)
  );

`ifdef IZH_SCHED_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_TICKS + 1);
  logic [RW-1:0] ref_cnt [NUM_NEURONS];
  logic          in_refrac;

  assign in_refrac = (ref_cnt[idx] != '0);
  assign spike     = core_spike && !in_refrac;

  // A refractory neuron is clamped at reset potential and its recovery frozen.
  always_comb begin
    nxt = core_nxt;
    if (in_refrac) begin
      nxt.v = IZH_C;
      nxt.u = cur_st.u;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) ref_cnt[k] <= '0;
    end else if (commit) begin
      if (in_refrac)       ref_cnt[idx] <= ref_cnt[idx] - 1'b1;
      else if (core_spike) ref_cnt[idx] <= RW'(REFRAC_TICKS);
    end
  end
`else
  assign spike = core_spike;
  assign nxt   = core_nxt;
`endif

  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
  assign spk_valid = (fifo_cnt != '0);
  assign spk_idx   = fifo_mem[rd_ptr];
  assign pop       = spk_valid && spk_ready;

  // A full FIFO that is popping this cycle still has room for the push.
  assign stall  = (state == S_RUN) && spike && fifo_full && !pop;
  assign commit = (state == S_RUN) && !stall;
  assign push   = commit && spike;

  assign rd_v = st_mem[rd_addr].v;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      tick_done    <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      tick_done    <= 1'b0;
      tick_overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            if (tick_done) begin
              tick_overrun <= 1'b1;
            end else begin
              state <= S_RUN;
              idx   <= '0;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (tick) tick_overrun <= 1'b1;
          if (stall) begin
            state <= S_STALL;
          end else if (idx == LAST_IDX) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            tick_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_STALL: begin
          if (tick) tick_overrun <= 1'b1;
          if (!fifo_full) state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // v/u are host-writable only between sweeps so a stalled neuron recomputes identically.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) st_mem[k] <= '0;
    end else if (commit) begin
      st_mem[idx] <= nxt;
    end else if (cfg_we && state == S_IDLE) begin
      if (cfg_sel == CFG_SEL_V)      st_mem[cfg_addr].v <= cfg_wdata;
      else if (cfg_sel == CFG_SEL_U) st_mem[cfg_addr].u <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) cur_mem[k] <= '0;
    end else if (cfg_we && cfg_sel == CFG_SEL_CUR) begin
      cur_mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench for izh_neuron_scheduler with hand-computed neuron trajectories.
module tb_izh_neuron_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [IW-1:0] cfg_addr;
  logic [7:0]    cfg_wdata;
  logic [IW-1:0] rd_addr;
  logic          spk_ready;
  logic          busy;
  logic          tick_done;
  logic          tick_overrun;
  logic [7:0]    rd_v;
  logic          spk_valid;
  logic [IW-1:0] spk_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  izh_neuron_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .busy         (busy),
    .tick_done    (tick_done),
    .tick_overrun (tick_overrun),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .rd_addr      (rd_addr),
    .rd_v         (rd_v),
    .spk_valid    (spk_valid),
    .spk_ready    (spk_ready),
    .spk_idx      (spk_idx)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tick      = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = 2'd0;
    cfg_addr  = '0;
    cfg_wdata = 8'd0;
    rd_addr   = '0;
    spk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int addr, input int data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = IW'(addr);
    cfg_wdata = 8'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_v(input string tag, input int addr, input int exp);
    rd_addr = IW'(addr);
    #1;
    check_eq(tag, int'(rd_v), exp);
  endtask

  task automatic start_tick();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Counts clock edges after the tick was taken until tick_done shows up.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!tick_done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!tick_done) check_eq("tick_done_timeout", 0, 1);
  endtask

  int cyc;
  int got [$];
  bit done_seen;

  initial begin
    // Reset clears a previously written v and all status outputs.
    do_reset();
    cfg_write(2'd1, 5, 77);
    check_v("pre_reset_v5", 5, 77);
    do_reset();
    check_v("reset_v5", 5, 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_tick_done", int'(tick_done), 0);
    check_eq("reset_overrun", int'(tick_overrun), 0);
    check_eq("reset_spk_valid", int'(spk_valid), 0);

    // Uniform drive I=8: v 0 -> 8 -> 57 -> 132 (the last step depends on u=12).
    for (int i = 0; i < N; i++) cfg_write(2'd0, i, 8);
    start_tick();
    wait_done(cyc);
    check_eq("sweep_latency", cyc, 8);
    for (int i = 0; i < N; i++) check_v($sformatf("t1_v%0d", i), i, 8);
    check_eq("t1_no_spike", int'(spk_valid), 0);
    start_tick();
    wait_done(cyc);
    for (int i = 0; i < N; i++) check_v($sformatf("t2_v%0d", i), i, 57);
    start_tick();
    wait_done(cyc);
    check_v("t3_v0", 0, 132);
    check_v("t3_v7", 7, 132);

    // Threshold spike on neuron 3: v=232 -> 60, u=4; next normal step gives 156.
    do_reset();
    cfg_write(2'd1, 3, 232);
    start_tick();
    wait_done(cyc);
    check_eq("spk_valid", int'(spk_valid), 1);
    check_eq("spk_idx", int'(spk_idx), 3);
    check_v("spk_v3", 3, 60);
    check_v("spk_v2", 2, 0);
    @(negedge clk);
    spk_ready = 1'b1;
    @(negedge clk);
    spk_ready = 1'b0;
    check_eq("spk_drained", int'(spk_valid), 0);
`ifdef IZH_SCHED_REFRACTORY_EN
    start_tick();
    wait_done(cyc);
    check_v("refrac1_v3", 3, 60);
    check_eq("refrac1_no_spike", int'(spk_valid), 0);
    start_tick();
    wait_done(cyc);
    check_v("refrac2_v3", 3, 60);
    check_eq("refrac2_no_spike", int'(spk_valid), 0);
`endif
    start_tick();
    wait_done(cyc);
    check_v("post_spike_v3", 3, 156);
    check_eq("post_spike_no_spike", int'(spk_valid), 0);

    // All neurons spike with the consumer stalled: FIFO fills at idx 4.
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(2'd1, i, 240);
    start_tick();
    repeat (12) @(negedge clk);
    check_eq("stall_busy", int'(busy), 1);
    check_eq("stall_spk_valid", int'(spk_valid), 1);
    check_eq("stall_head", int'(spk_idx), 0);
    check_v("stall_v3", 3, 60);
    check_v("stall_v4", 4, 240);
    spk_ready = 1'b1;
    done_seen = 1'b0;
    got.delete();
    for (int k = 0; k < 60; k++) begin
      if (spk_valid) got.push_back(int'(spk_idx));
      if (tick_done) done_seen = 1'b1;
      if (done_seen && !spk_valid) break;
      @(negedge clk);
    end
    spk_ready = 1'b0;
    check_eq("drain_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check_eq($sformatf("drain_order%0d", i), got[i], i);
    check_eq("drain_tick_done", int'(done_seen), 1);
    check_eq("drain_busy", int'(busy), 0);
    check_v("drain_v7", 7, 60);

    // Tick during RUN is an overrun and does not restart the sweep.
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(2'd0, i, 8);
    start_tick();
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    check_eq("overrun_run", int'(tick_overrun), 1);
    wait_done(cyc);
    // Tick coinciding with tick_done is also an overrun.
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    check_eq("overrun_at_done", int'(tick_overrun), 1);
    repeat (3) @(negedge clk);
    check_eq("overrun_idle", int'(busy), 0);
    for (int i = 0; i < N; i++) check_v($sformatf("ovr_v%0d", i), i, 8);

    // v write while busy is dropped; the scheduler result stands.
    start_tick();
    cfg_we    = 1'b1;
    cfg_sel   = 2'd1;
    cfg_addr  = IW'(2);
    cfg_wdata = 8'd100;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_done(cyc);
    check_v("drop_v2", 2, 57);
    check_v("drop_v1", 1, 57);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
